// File: rtl/iob_ptfloat_pack.sv
// pt-float packer: normalizes an (exponent, two's-complement mantissa) pair,
// handles subnormals and saturation, and encodes it with the minimal ew field
// and round-to-nearest-even.
module iob_ptfloat_pack #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned EW_W   = 4,
  parameter int unsigned EW_MAX = 2**EW_W - 1,
  parameter int unsigned F_W    = DATA_W - EW_W,
  parameter int unsigned MAN_W  = F_W + 1,
  parameter int unsigned EXP_W  = EW_MAX + 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cke_i,
  input  logic              start_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [MAN_W-1:0]  man_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o
);

  // Internal exponent carries two guard bits so normalization cannot wrap.
  localparam int unsigned XW = EXP_W + 2;
  localparam int unsigned RW = MAN_W + 1;
  localparam int unsigned SW = $clog2(F_W + 1);
  localparam logic signed [XW-1:0] EMIN   = XW'(-(2**EW_MAX - 2));
  localparam logic signed [XW-1:0] EMAX_N = XW'(2**EW_MAX - 1);

  typedef enum logic [2:0] {IDLE, NORM, SUB, ENC, DONE} state_t;

  state_t               state, state_n;
  logic [MAN_W-1:0]     man_q, man_d;
  logic signed [XW-1:0] exp_q, exp_d;
  logic                 zero_q, zero_d, sub_q, sub_d;
  logic                 busy_d, done_d;
  logic [DATA_W-1:0]    data_d;

  logic                 norm_ok, man_zero, sub_zero, sub_ones, sub_last;
  logic [MAN_W-1:0]     man_asr;
  logic signed [XW-1:0] exp_inc, exp_dec, exp_ext;

  assign exp_ext  = {{(XW-EXP_W){exp_i[EXP_W-1]}}, exp_i};
  assign norm_ok  = man_q[MAN_W-1] ^ man_q[MAN_W-2];
  assign man_zero = (man_q == '0);
  assign man_asr  = {man_q[MAN_W-1], man_q[MAN_W-1:1]};
  assign exp_inc  = exp_q + XW'(1);
  assign exp_dec  = exp_q - XW'(1);
  assign sub_zero = (man_asr == '0);
  assign sub_ones = &man_asr;
  assign sub_last = sub_ones || (exp_inc == EMIN);

  logic [XW-1:0]        mag, fld_s;
  logic [EW_W-1:0]      ew;
  logic [SW-1:0]        fsh;
  logic [F_W-1:0]       fld, frac, payload;
  logic [RW-1:0]        m_ext, low_mask, dropped, half, back;
  logic signed [RW-1:0] kept, rounded;
  logic                 rnd_up, sat, ovf_pos, ovf_neg;
  logic [DATA_W-1:0]    enc_word;

  // Encoder: ew selection, field extraction, RNE rounding and overflow detect.
  always_comb begin
    mag = exp_q[XW-1] ? XW'(-exp_q) : exp_q;
    ew  = '0;
    for (int i = 0; i < int'(XW); i++) begin
      if (mag[i]) ew = EW_W'(i + 1);
    end
    if (sub_q) ew = EW_W'(EW_MAX);
    fld_s    = (!exp_q[XW-1] && (exp_q != '0)) ? exp_q : exp_dec;
    fld      = F_W'(fld_s) & ((F_W'(1) << ew) - F_W'(1));
    fsh      = SW'(F_W) - SW'(ew);
    m_ext    = {man_q[MAN_W-1], man_q};
    kept     = $signed(m_ext) >>> ew;
    low_mask = (RW'(1) << ew) - RW'(1);
    dropped  = m_ext & low_mask;
    half     = (ew == '0) ? '0 : (RW'(1) << (ew - EW_W'(1)));
    rnd_up   = (ew != '0) && ((dropped > half) || ((dropped == half) && kept[0]));
    rounded  = kept + RW'(rnd_up);
    back     = rounded << ew;
    frac     = back[F_W-1:0] >> ew;
    sat      = !zero_q && !sub_q && (exp_q > EMAX_N);
    ovf_pos  = !zero_q && !sat && !sub_q && (back[RW-1] != back[RW-2]);
    ovf_neg  = !zero_q && !sat && !sub_q && !ovf_pos && (back[RW-2] == back[RW-3]);
    payload  = frac;
    if (!sub_q) payload = payload | (fld << fsh);
    if (zero_q) begin
      enc_word = {F_W'(0), EW_W'(EW_MAX)};
    end else if (sat) begin
      if (man_q[MAN_W-1]) enc_word = {{EW_MAX{1'b1}}, {(F_W-EW_MAX){1'b0}}, EW_W'(EW_MAX)};
      else                enc_word = '1;
    end else begin
      enc_word = {payload, ew};
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i)      state <= IDLE;
    else if (cke_i) state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_i) state_n = NORM;
      NORM: begin
        if (man_zero)     state_n = ENC;
        else if (norm_ok) state_n = (exp_q < EMIN) ? SUB : ENC;
      end
      SUB:     if (sub_zero || sub_last) state_n = ENC;
      ENC:     if (!(ovf_pos || ovf_neg)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    man_d  = man_q;
    exp_d  = exp_q;
    zero_d = zero_q;
    sub_d  = sub_q;
    data_d = data_o;
    case (state)
      IDLE: begin
        if (start_i) begin
          man_d  = man_i;
          exp_d  = exp_ext;
          zero_d = 1'b0;
          sub_d  = 1'b0;
        end
      end
      NORM: begin
        if (man_zero) begin
          zero_d = 1'b1;
        end else if (!norm_ok) begin
          man_d = {man_q[MAN_W-2:0], 1'b0};
          exp_d = exp_dec;
        end
      end
      SUB: begin
        man_d = man_asr;
        exp_d = exp_inc;
        if (sub_zero) begin
          zero_d = 1'b1;
        end else if (sub_ones) begin
          exp_d = EMIN;
          sub_d = 1'b1;
        end else if (sub_last) begin
          sub_d = 1'b1;
        end
      end
      ENC: begin
        if (ovf_pos) begin
          man_d = MAN_W'(1) << (MAN_W - 2);
          exp_d = exp_inc;
        end else if (ovf_neg) begin
          man_d = MAN_W'(1) << (MAN_W - 1);
          exp_d = exp_dec;
        end else begin
          data_d = enc_word;
        end
      end
      default: ;
    endcase
    busy_d = (state_n == NORM) || (state_n == SUB) || (state_n == ENC);
    done_d = (state_n == DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      man_q  <= '0;
      exp_q  <= '0;
      zero_q <= 1'b0;
      sub_q  <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      data_o <= '0;
    end else if (cke_i) begin
      man_q  <= man_d;
      exp_q  <= exp_d;
      zero_q <= zero_d;
      sub_q  <= sub_d;
      busy_o <= busy_d;
      done_o <= done_d;
      data_o <= data_d;
    end
  end

endmodule

// File: tb/tb_iob_ptfloat_pack.sv
// Directed self-checking bench for iob_ptfloat_pack.
module tb_iob_ptfloat_pack;

  logic        clk = 1'b0;
  logic        rst, cke, start;
  logic [16:0] e_in;
  logic [28:0] m_in;
  logic        busy, done;
  logic [31:0] data;

  int checks = 0;
  int errors = 0;

  logic [31:0] d;
  int          lat;
  logic        b1;

  iob_ptfloat_pack dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .cke_i  (cke),
    .start_i(start),
    .exp_i  (e_in),
    .man_i  (m_in),
    .busy_o (busy),
    .done_o (done),
    .data_o (data)
  );

  always #5 clk = ~clk;

  // Issue one operation from IDLE and wait (bounded) for done.
  task automatic do_op(input logic [16:0] e, input logic [28:0] m,
                       output logic [31:0] dd, output int l, output logic bb);
    @(posedge clk); #1;
    start = 1'b1; e_in = e; m_in = m;
    @(posedge clk); #1;
    start = 1'b0; l = 1; bb = busy;
    while (done !== 1'b1 && l < 200) begin
      @(posedge clk); #1;
      l++;
    end
    dd = data;
  endtask

  task automatic test_reset;
    rst = 1'b1; cke = 1'b1; start = 1'b0; e_in = '0; m_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", data); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    do_op(17'd0, 29'h0800_0000, d, lat, b1);
    checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL basic_e0 data got %h want 80000000", d); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_e0 latency got %0d want 3", lat); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL basic_e0 busy got %b want 1", b1); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_pulse done %b busy %b want 0 0", done, busy); end
    checks++; if (data !== 32'h8000_0000) begin errors++; $display("FAIL data_hold got %h want 80000000", data); end
    do_op(17'd1, 29'h0C00_0000, d, lat, b1);
    checks++; if (d !== 32'hE000_0001) begin errors++; $display("FAIL basic_e1 data got %h want e0000001", d); end
    do_op(17'h1FFFF, 29'h0800_0000, d, lat, b1);
    checks++; if (d !== 32'h4000_0001) begin errors++; $display("FAIL basic_em1 data got %h want 40000001", d); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_em1 latency got %0d want 3", lat); end
  endtask

  task automatic test_norm;
    do_op(17'd5, 29'h0200_0000, d, lat, b1);
    checks++; if (d !== 32'hE000_0002) begin errors++; $display("FAIL norm data got %h want e0000002", d); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL norm latency got %0d want 5", lat); end
  endtask

  task automatic test_round;
    do_op(17'd1, 29'h0FFF_FFFF, d, lat, b1);
    checks++; if (d !== 32'hA000_0002) begin errors++; $display("FAIL round_ovf data got %h want a0000002", d); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL round_ovf latency got %0d want 4", lat); end
    do_op(17'd1, 29'h0800_0001, d, lat, b1);
    checks++; if (d !== 32'hC000_0001) begin errors++; $display("FAIL round_tie_even data got %h want c0000001", d); end
    do_op(17'd1, 29'h0800_0003, d, lat, b1);
    checks++; if (d !== 32'hC000_0021) begin errors++; $display("FAIL round_tie_up data got %h want c0000021", d); end
    do_op(17'd3, 29'h0800_0003, d, lat, b1);
    checks++; if (d !== 32'hE000_0012) begin errors++; $display("FAIL round_above data got %h want e0000012", d); end
    do_op(17'd2, 29'h17FF_FFFF, d, lat, b1);
    checks++; if (d !== 32'h8000_0001) begin errors++; $display("FAIL round_neg_ovf data got %h want 80000001", d); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL round_neg_ovf latency got %0d want 4", lat); end
  endtask

  task automatic test_special;
    do_op(17'd0, 29'h0, d, lat, b1);
    checks++; if (d !== 32'h0000_000F) begin errors++; $display("FAIL zero data got %h want 0000000f", d); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL zero latency got %0d want 3", lat); end
    do_op(17'd40000, 29'h0800_0000, d, lat, b1);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_pos data got %h want ffffffff", d); end
    do_op(17'd40000, 29'h1000_0000, d, lat, b1);
    checks++; if (d !== 32'hFFFE_000F) begin errors++; $display("FAIL sat_neg data got %h want fffe000f", d); end
    do_op(17'(-32767), 29'h0800_0000, d, lat, b1);
    checks++; if (d !== 32'h0000_800F) begin errors++; $display("FAIL subnormal data got %h want 0000800f", d); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL subnormal latency got %0d want 4", lat); end
  endtask

  task automatic test_start_while_busy;
    @(posedge clk); #1;
    start = 1'b1; e_in = 17'd1; m_in = 29'h0C00_0000;
    @(posedge clk); #1;
    lat = 1;
    e_in = 17'h1FFFF; m_in = 29'h0800_0000;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    start = 1'b0;
    checks++; if (data !== 32'hE000_0001) begin errors++; $display("FAIL busy_ignore data got %h want e0000001", data); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL busy_ignore latency got %0d want 3", lat); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignore restart busy got %b want 0", busy); end
  endtask

  task automatic test_cke;
    @(posedge clk); #1;
    start = 1'b1; e_in = 17'd0; m_in = 29'h0800_0000;
    @(posedge clk); #1;
    start = 1'b0; cke = 1'b0; lat = 1;
    repeat (2) begin @(posedge clk); #1; lat++; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cke_hold busy got %b want 1", busy); end
    cke = 1'b1;
    while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 5) begin errors++; $display("FAIL cke_stretch latency got %0d want 5", lat); end
    checks++; if (data !== 32'h8000_0000) begin errors++; $display("FAIL cke_stretch data got %h want 80000000", data); end
  endtask

  task automatic test_reset_abort;
    logic seen;
    @(posedge clk); #1;
    start = 1'b1; e_in = 17'd5; m_in = 29'h0200_0000;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre busy got %b want 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL abort_data got %h want 00000000", data); end
    seen = done;
    repeat (6) begin @(posedge clk); #1; seen = seen | done; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b want 0", seen); end
    do_op(17'd1, 29'h0C00_0000, d, lat, b1);
    checks++; if (d !== 32'hE000_0001) begin errors++; $display("FAIL abort_restart data got %h want e0000001", d); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL abort_restart latency got %0d want 3", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_norm();
    test_round();
    test_special();
    test_start_while_busy();
    test_cke();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
